spi_master_tx: RTL and testbench

SPI master transmitter for the mode‑0 link (CPOL=0, CPHA=0, MSB first, CS active low). It accepts an N‑bit word over a start/busy/done handshake, drives CS, SCK and MOSI from the system clock, and signals completion. It is the sending end for the team's SPI receivers, which sample SCK/MOSI/CS through 2‑flop synchronizers and capture on the rising SCK edge.

---
 rtl/spi_master_tx.sv | 145 ++++++++++++++
 tb/tb_spi_master_tx.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_master_tx.sv
// SPI mode-0 master transmitter (CPOL=0, CPHA=0, MSB first, CS active low).
// Outputs are registered from the next-state values, so each output changes
// on the same clk edge as the state it belongs to, with no combinational path.
`timescale 1ns/1ps
module spi_master_tx #(
  parameter int N       = 8,
  parameter int CLK_DIV = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [N-1:0] data_in,
  output logic         SCK,
  output logic         MOSI,
  output logic         CS,
  output logic         busy,
  output logic         done
);

  localparam int CNT_W = $clog2(CLK_DIV);
  localparam int BIT_W = $clog2(N) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LOAD = BIT_W'(N - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    HIGH  = 3'd2,
    LOW   = 3'd3,
    GAP   = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [BIT_W-1:0] bit_q, bit_d;
  logic [N-1:0]     shift_q, shift_d;
  logic             sck_q, sck_d;
  logic             mosi_q, mosi_d;
  logic             cs_q, cs_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             phase_end;

  // State, datapath and output registers; reset returns everything to idle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      sck_q   <= 1'b0;
      mosi_q  <= 1'b0;
      cs_q    <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      sck_q   <= sck_d;
      mosi_q  <= mosi_d;
      cs_q    <= cs_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Next-state logic: phase sequencing, bit counting and shifting.
  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_d     = bit_q;
    phase_end = (cnt_q == CNT_LAST);
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = SETUP;
          shift_d = data_in;
          bit_d   = BIT_LOAD;
        end
      end
      SETUP: begin
        if (phase_end) state_d = HIGH;
      end
      HIGH: begin
        if (phase_end) begin
          state_d = LOW;
          // Present the next bit at the falling edge, unless this was the last.
          if (bit_q != '0) shift_d = shift_q << 1;
        end
      end
      LOW: begin
        if (phase_end) begin
          if (bit_q != '0) begin
            state_d = HIGH;
            bit_d   = bit_q - 1'b1;
          end else begin
            state_d = GAP;
          end
        end
      end
      GAP: begin
        if (phase_end) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Half-period counter restarts on every state change and rests in IDLE.
    if ((state_d != state_q) || (state_q == IDLE)) cnt_d = '0;
    else                                           cnt_d = cnt_q + 1'b1;
  end

  // Output decode from the upcoming state so the output flops track it.
  always_comb begin
    sck_d  = 1'b0;
    mosi_d = 1'b0;
    cs_d   = 1'b1;
    busy_d = 1'b0;
    done_d = (state_q == GAP) && (state_d == IDLE);
    case (state_d)
      SETUP, LOW: begin
        cs_d   = 1'b0;
        mosi_d = shift_d[N-1];
        busy_d = 1'b1;
      end
      HIGH: begin
        cs_d   = 1'b0;
        sck_d  = 1'b1;
        mosi_d = shift_d[N-1];
        busy_d = 1'b1;
      end
      GAP: begin
        busy_d = 1'b1;
      end
      default: ;
    endcase
  end

  assign SCK  = sck_q;
  assign MOSI = mosi_q;
  assign CS   = cs_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_spi_master_tx.sv
// Scoreboard bench for spi_master_tx: an 8-bit/H=4 instance and a 16-bit/H=6
// instance share clk and reset. A mode-0 loopback receiver captures each word.
`timescale 1ns/1ps
module tb_spi_master_tx;

  typedef struct packed {
    logic        ch;
    logic [15:0] w;
  } sb_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  start_w = 2'b00;
  logic [15:0] data_w [2];
  logic [1:0]  sck_w, mosi_w, cs_w, busy_w, done_w;

  sb_t sbq[$];
  int  n_cmp = 0;
  int  n_err = 0;
  int  cyc = 0;

  // Receiver / monitor state, per channel
  int          acc [2];
  int          rises [2];
  int          cs_low_n [2];
  int          mosi_bad [2];
  int          high_run [2];
  int          last_gap [2];
  int          done_cnt [2];
  logic [15:0] rx [2];
  logic        pend [2];
  logic        sck_p [2];
  logic        cs_p [2];
  logic        mosi_p [2];

  spi_master_tx #(.N(8), .CLK_DIV(4)) dut8 (
    .clk(clk), .reset(reset), .start(start_w[0]), .data_in(data_w[0][7:0]),
    .SCK(sck_w[0]), .MOSI(mosi_w[0]), .CS(cs_w[0]), .busy(busy_w[0]), .done(done_w[0])
  );

  spi_master_tx #(.N(16), .CLK_DIV(6)) dut16 (
    .clk(clk), .reset(reset), .start(start_w[1]), .data_in(data_w[1]),
    .SCK(sck_w[1]), .MOSI(mosi_w[1]), .CS(cs_w[1]), .busy(busy_w[1]), .done(done_w[1])
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached (got running, need finished)");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Monitor on the falling edge; inputs are driven 2ns after the rising edge,
  // so what is seen here is what the next rising edge will sample.
  int          nb, hh, rel;
  logic [15:0] mask;
  sb_t         e;
  always @(negedge clk) begin
    for (int c = 0; c < 2; c++) begin
      nb   = (c == 0) ? 8 : 16;
      hh   = (c == 0) ? 4 : 6;
      mask = (c == 0) ? 16'h00FF : 16'hFFFF;
      if (reset) begin
        pend[c]     = 1'b0;
        rises[c]    = 0;
        rx[c]       = '0;
        cs_low_n[c] = 0;
        mosi_bad[c] = 0;
        high_run[c] = 0;
      end else begin
        if (pend[c]) begin
          acc[c]      = cyc;
          rises[c]    = 0;
          rx[c]       = '0;
          cs_low_n[c] = 0;
          mosi_bad[c] = 0;
        end
        rel = cyc - acc[c] + 1;
        if (!cs_w[c]) cs_low_n[c]++;
        if (cs_p[c] && !cs_w[c]) begin
          last_gap[c] = high_run[c];
          check($sformatf("cs_fall_cyc%0d", c), rel, 1);
        end
        if (cs_w[c]) high_run[c]++;
        else         high_run[c] = 0;
        if (sck_w[c] && !sck_p[c]) begin
          check($sformatf("sck_rise%0d_cyc_ch%0d", rises[c], c), rel, 1 + hh + 2 * hh * rises[c]);
          rx[c] = {rx[c][14:0], mosi_w[c]};
          rises[c]++;
        end
        if (!cs_w[c] && !cs_p[c] && (mosi_w[c] != mosi_p[c]) && !(sck_p[c] && !sck_w[c]))
          mosi_bad[c]++;
        if (done_w[c]) begin
          done_cnt[c]++;
          if (sbq.size() == 0) begin
            check($sformatf("sb_pop_ch%0d", c), 32'd0, 32'd1);
          end else begin
            e = sbq.pop_front();
            $display("xfer ch%0d: rx=0x%0h exp=0x%0h rises=%0d done_cyc=%0d", c, rx[c] & mask, e.w, rises[c], rel);
            check("sb_chan", c, e.ch);
            check("rx_word", rx[c] & mask, e.w);
            check("sck_rises", rises[c], nb);
            check("done_cyc", rel, hh * (2 * nb + 2) + 1);
            check("cs_low_len", cs_low_n[c], hh * (2 * nb + 1));
            check("mosi_stable", mosi_bad[c], 0);
            check("busy_at_done", busy_w[c], 1'b0);
          end
        end
        pend[c] = start_w[c] && !busy_w[c];
      end
      sck_p[c]  = sck_w[c];
      cs_p[c]   = cs_w[c];
      mosi_p[c] = mosi_w[c];
    end
  end

  task automatic wait_done(input int c, input int base, input int budget);
    int n = 0;
    while (done_cnt[c] == base && n < budget) begin
      @(posedge clk);
      n++;
    end
    check($sformatf("done_seen_ch%0d", c), done_cnt[c] != base, 1'b1);
  endtask

  task automatic wait_idle(input int c);
    int n = 0;
    while (busy_w[c] && n < 400) begin
      @(posedge clk);
      n++;
    end
  endtask

  task automatic send_wait(input int c, input logic [15:0] w);
    int base;
    wait_idle(c);
    base = done_cnt[c];
    @(posedge clk); #2;
    start_w[c] = 1'b1;
    data_w[c]  = w;
    sbq.push_back('{ch: c[0], w: w});
    @(posedge clk); #2;
    start_w[c] = 1'b0;
    data_w[c]  = 16'($urandom);
    wait_done(c, base, 400);
  endtask

  task automatic check_reset_outs(input string tag);
    check({tag, "_sck"},  sck_w[0],  1'b0);
    check({tag, "_cs"},   cs_w[0],   1'b1);
    check({tag, "_mosi"}, mosi_w[0], 1'b0);
    check({tag, "_busy"}, busy_w[0], 1'b0);
    check({tag, "_done"}, done_w[0], 1'b0);
  endtask

  initial begin
    int base, n;
    data_w[0] = '0;
    data_w[1] = '0;
    for (int c = 0; c < 2; c++) begin
      acc[c] = 0; rises[c] = 0; cs_low_n[c] = 0; mosi_bad[c] = 0;
      high_run[c] = 0; last_gap[c] = 0; done_cnt[c] = 0; rx[c] = '0;
      pend[c] = 1'b0; sck_p[c] = 1'b0; cs_p[c] = 1'b1; mosi_p[c] = 1'b0;
    end

    // Reset state, then an asynchronous re-assert in mid-cycle
    repeat (3) @(posedge clk);
    #2 check_reset_outs("rst_hold");
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #2 reset = 1'b1;
    #1 check_reset_outs("rst_async");
    repeat (2) @(posedge clk);
    #2 check_reset_outs("rst_held");
    reset = 1'b0;
    repeat (2) @(posedge clk);

    // Single word
    send_wait(0, 16'h00A5);

    // Busy lockout: a second request during the transfer is ignored
    base = done_cnt[0];
    @(posedge clk); #2;
    start_w[0] = 1'b1; data_w[0] = 16'h003C;
    sbq.push_back('{ch: 1'b0, w: 16'h003C});
    @(posedge clk); #2;
    start_w[0] = 1'b0;
    repeat (20) @(posedge clk);
    #2 start_w[0] = 1'b1; data_w[0] = 16'h00FF;
    repeat (2) @(posedge clk);
    #2 start_w[0] = 1'b0;
    wait_done(0, base, 400);
    repeat (40) @(posedge clk);
    check("lock_done_count", done_cnt[0], base + 1);
    check("lock_busy_idle", busy_w[0], 1'b0);

    // Back-to-back with start held high
    base = done_cnt[0];
    @(posedge clk); #2;
    start_w[0] = 1'b1; data_w[0] = 16'h0000;
    sbq.push_back('{ch: 1'b0, w: 16'h0000});
    sbq.push_back('{ch: 1'b0, w: 16'h00FF});
    @(posedge clk); #2;
    data_w[0] = 16'h00FF;
    wait_done(0, base, 400);
    #2 start_w[0] = 1'b0;
    wait_done(0, base + 1, 400);
    check("b2b_cs_gap", last_gap[0], 5);

    // Reset in the middle of a transfer
    wait_idle(0);
    base = done_cnt[0];
    @(posedge clk); #2;
    start_w[0] = 1'b1; data_w[0] = 16'h0081;
    sbq.push_back('{ch: 1'b0, w: 16'h0081});
    @(posedge clk); #2;
    start_w[0] = 1'b0;
    n = 0;
    while (rises[0] < 3 && n < 200) begin
      @(posedge clk);
      n++;
    end
    check("mid_third_rise", rises[0] >= 3, 1'b1);
    repeat (2) @(posedge clk);
    #2 reset = 1'b1;
    #1 check_reset_outs("rst_mid");
    sbq.delete();
    repeat (3) @(posedge clk);
    #2 reset = 1'b0;
    repeat (80) @(posedge clk);
    check("mid_no_done", done_cnt[0], base);
    send_wait(0, 16'h005A);

    // Wider word, slower SCK
    send_wait(1, 16'h8001);

    repeat (5) @(posedge clk);
    check("sb_drained", sbq.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
